// File: rtl/conv_pkg.sv
// conv_pkg: shared types for the convolution buffer reader and its pixel FIFO.
package conv_pkg;
  typedef logic [7:0] pixel_t;
  typedef logic [7:0] idx_t;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} reader_state_t;
  typedef struct packed {logic last_col; logic last;} tag_t;
  typedef struct packed {pixel_t data; tag_t tag;} beat_t;
endpackage

// File: rtl/conv_pix_fifo.sv
// conv_pix_fifo: synchronous FIFO whose empty head shows the incoming push, so data reaches the consumer the cycle it arrives.
module conv_pix_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] cnt_q;
  logic byp, wr, rd;
  // A push popped in the same cycle while empty passes straight through.
  assign byp = cnt_q == '0;
  assign wr = push_i && !(byp && pop_i);
  assign rd = pop_i && !byp;
  assign dout_o = byp ? din_i : mem_q[rd_q];
  assign empty_o = byp && !push_i;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign count_o = cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (wr) mem_q[wr_q] <= din_i;
      if (wr) wr_q <= wr_q + 1'b1;
      if (rd) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/conv_buf_reader.sv
// conv_buf_reader: raster-scan reader of the buffer SRAM, streaming pixels (optionally transposed) on valid/ready.
module conv_buf_reader
  import conv_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] nrows,
  input  logic [7:0] ncols,
  input  logic       transpose,
  output logic       busy,
  output logic       done,
  output logic [7:0] sram_row,
  output logic [7:0] sram_col,
  output logic [7:0] sram_din,
  input  logic [7:0] sram_dout,
  output logic       sram_write_en,
  output logic       sram_sense_en,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last_col,
  output logic       m_last
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  reader_state_t state_q, state_d;
  idx_t o_q, o_d, i_q, i_d, nr_q, nr_d, nc_q, nc_d;
  logic tr_q, tr_d, infl_q;
  tag_t tag_q, tag_d;
  beat_t head, beat_in;
  logic [CW-1:0] cnt;
  logic [CW:0] occ;
  logic empty, full, pop, issue, last_i, last_o;
  assign pop = m_valid && m_ready;
  assign last_i = i_q == nc_q - 8'd1;
  assign last_o = o_q == nr_q - 8'd1;
  // Occupancy after this cycle's push and pop; a new read must still find a free slot.
  assign occ = (CW+1)'(cnt) + (CW+1)'(infl_q) - (CW+1)'(pop);
  assign issue = state_q == SCAN && occ < (CW+1)'(FIFO_DEPTH);
  assign tag_d = '{last_col: last_i, last: last_i && last_o};
  assign beat_in = '{data: sram_dout, tag: tag_q};
  assign sram_row = tr_q ? i_q : o_q;
  assign sram_col = tr_q ? o_q : i_q;
  assign sram_din = '0;
  assign sram_write_en = 1'b0;
  assign sram_sense_en = issue;
  assign busy = state_q != IDLE;
  assign done = state_q == FIN;
  assign m_valid = !empty;
  assign m_data = m_valid ? head.data : '0;
  assign m_last_col = m_valid && head.tag.last_col;
  assign m_last = m_valid && head.tag.last;
  always_comb begin
    state_d = state_q;
    o_d = o_q;
    i_d = i_q;
    nr_d = nr_q;
    nc_d = nc_q;
    tr_d = tr_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = (nrows == '0 || ncols == '0) ? FIN : SCAN;
        nr_d = nrows;
        nc_d = ncols;
        tr_d = transpose;
        o_d = '0;
        i_d = '0;
      end
      SCAN: if (issue) begin
        i_d = last_i ? '0 : i_q + 8'd1;
        o_d = !last_i ? o_q : last_o ? '0 : o_q + 8'd1;
        state_d = (last_i && last_o) ? DRAIN : SCAN;
      end
      DRAIN: state_d = (pop && head.tag.last) ? FIN : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      o_q <= '0;
      i_q <= '0;
      nr_q <= '0;
      nc_q <= '0;
      tr_q <= 1'b0;
      infl_q <= 1'b0;
      tag_q <= '0;
    end else begin
      state_q <= state_d;
      o_q <= o_d;
      i_q <= i_d;
      nr_q <= nr_d;
      nc_q <= nc_d;
      tr_q <= tr_d;
      infl_q <= issue;
      tag_q <= tag_d;
    end
  end
  always_ff @(posedge clk) if (!rst) assert (!(full && infl_q && !pop));
  conv_pix_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(beat_t))) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(infl_q),
    .din_i(beat_in),
    .pop_i(pop),
    .dout_o(head),
    .empty_o(empty),
    .full_o(full),
    .count_o(cnt)
  );
endmodule

// File: tb/tb_conv_buf_reader.sv
// tb_conv_buf_reader: scoreboard bench; the image model pushes expected pixels, a monitor checks every handshake.
module tb_conv_buf_reader;
  logic clk = 0, rst = 1, start = 0, transpose = 0, m_ready = 0;
  logic [7:0] nrows = 0, ncols = 0;
  logic busy, done, m_valid, m_last_col, m_last, sram_write_en, sram_sense_en;
  logic [7:0] m_data, sram_row, sram_col, sram_din;
  logic [7:0] sram_dout = 0;
  int n_chk = 0, n_fail = 0, cyc = 0, hs = 0, iss = 0, done_cyc = -1, first_cyc = -1;
  logic [9:0] exp_q[$];
  logic stall_v = 0;
  logic [9:0] stall_p = 0;
  conv_buf_reader #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .start(start), .nrows(nrows), .ncols(ncols), .transpose(transpose),
    .busy(busy), .done(done), .sram_row(sram_row), .sram_col(sram_col), .sram_din(sram_din),
    .sram_dout(sram_dout), .sram_write_en(sram_write_en), .sram_sense_en(sram_sense_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last_col(m_last_col), .m_last(m_last)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] pix(input int r, input int c);
    return 8'(r * 7 + c * 13 + 1);
  endfunction
  always @(posedge clk) if (sram_sense_en) sram_dout <= pix(int'(sram_row), int'(sram_col));
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) stall_v = 0;
    else begin
      chk("write_en", int'(sram_write_en), 0);
      if (sram_sense_en) begin
        chk("read_room", int'((iss - hs - int'(m_valid && m_ready)) < 2), 1);
        iss++;
      end
      if (m_valid && first_cyc < 0) first_cyc = cyc;
      if (done) done_cyc = cyc;
      if (stall_v) begin
        chk("stall_valid", int'(m_valid), 1);
        chk("stall_payload", int'({m_data, m_last_col, m_last}), int'(stall_p));
      end
      stall_v = m_valid && !m_ready;
      stall_p = {m_data, m_last_col, m_last};
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("extra_pixel", 1, 0);
        else chk("pixel", int'({m_data, m_last_col, m_last}), int'(exp_q.pop_front()));
        hs++;
      end
    end
  end
  task automatic start_img(input int nr, input int nc, input logic tr, output int s);
    for (int o = 0; o < nr; o++)
      for (int i = 0; i < nc; i++) begin
        logic lc, l;
        lc = (i == nc - 1);
        l = lc && (o == nr - 1);
        exp_q.push_back({tr ? pix(i, o) : pix(o, i), lc, l});
      end
    @(posedge clk); #1;
    nrows = 8'(nr); ncols = 8'(nc); transpose = tr; start = 1;
    first_cyc = -1; done_cyc = -1; iss = 0; hs = 0;
    @(posedge clk); #1;
    s = cyc;
    start = 0; nrows = 8'd1; ncols = 8'd1; transpose = ~tr;
  endtask
  task automatic wait_done(input int budget, input bit rnd);
    int n = 0;
    while (done_cyc < 0 && n < budget) begin
      @(posedge clk); #1;
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      n++;
    end
    m_ready = 1;
    chk("done_seen", int'(done_cyc >= 0), 1);
    chk("queue_empty", exp_q.size(), 0);
  endtask
  initial begin
    int s, n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_data", int'({m_data, m_last_col, m_last}), 0);
    chk("rst_sram", int'({sram_row, sram_col, sram_din, sram_sense_en, sram_write_en}), 0);
    rst = 0;
    m_ready = 1;
    start_img(3, 4, 0, s);
    chk("busy_scan", int'(busy), 1);
    wait_done(100, 0);
    chk("rm_first", first_cyc - s + 1, 2);
    chk("rm_done", done_cyc - s + 1, 14);
    chk("rm_count", hs, 12);
    start_img(3, 4, 1, s);
    repeat (2) @(posedge clk);
    #1; start = 1; nrows = 8'd2; ncols = 8'd2;
    @(posedge clk); #1; start = 0;
    wait_done(100, 0);
    chk("tr_done", done_cyc - s + 1, 14);
    chk("tr_count", hs, 12);
    m_ready = 0;
    start_img(6, 6, 0, s);
    wait_done(1000, 1);
    chk("rnd_count", hs, 36);
    chk("rnd_reads", iss, 36);
    start_img(0, 5, 0, s);
    wait_done(20, 0);
    repeat (3) @(posedge clk);
    chk("zero_done", done_cyc - s + 1, 1);
    chk("zero_reads", iss, 0);
    chk("zero_valid", first_cyc, -1);
    start_img(4, 4, 0, s);
    n = 0;
    while (hs < 7 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mid_reached", int'(hs >= 7), 1);
    rst = 1;
    @(posedge clk); #1;
    chk("mid_busy", int'(busy), 0);
    chk("mid_valid", int'(m_valid), 0);
    rst = 0;
    exp_q.delete();
    start_img(4, 4, 0, s);
    wait_done(100, 0);
    chk("rescan_done", done_cyc - s + 1, 18);
    chk("rescan_count", hs, 16);
    start_img(255, 255, 0, s);
    wait_done(70000, 0);
    chk("big_done", done_cyc - s + 1, 65027);
    chk("big_count", hs, 65025);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_buf_reader.md
# conv_buf_reader

Raster-scan reader for the intermediate buffer SRAM. It reads an nrows x ncols image of 8-bit pixels through an img_sram_intf master port and streams the pixels out on a valid/ready interface, optionally transposed. It sits downstream of the row-convolution pass and feeds either the second (column) pass or the output/DMA path. It absorbs the SRAM's one-cycle read latency and downstream backpressure without dropping or duplicating pixels.

## Interface
- FIFO_DEPTH, 2: output skid FIFO depth (≥2, power of two).
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- nrows  in  8  row count, latched on accepted start.
- ncols  in  8  column count, latched on accepted start.
- transpose  in  1  1 = column-major scan (address row/col swapped); latched on start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last pixel handshakes.
- sram  img_sram_intf.mst  the buffer SRAM port (row, col, din, dout, write_en, sense_en).
- m_data  out  8  pixel.
- m_valid  out  1  m_data valid.
- m_ready  in  1  consumer accepts; a transfer occurs when m_valid && m_ready.
- m_last_col  out  1  qualifies the final pixel of each scan line.
- m_last  out  1  qualifies the final pixel of the image.

## Operation
- Reset values: busy=0, done=0, m_valid=0, m_data=0, m_last_col=0, m_last=0, sram.write_en=0, sram.sense_en=0, sram.row=0, sram.col=0, sram.din=0. The FIFO is empty and all counters are 0.
- sram.write_en is held at 0 at all times. sram.sense_en=1 only in a cycle that issues a read.
- States:
  - IDLE to SCAN on start. If nrows==0 or ncols==0, IDLE goes to FIN instead.
  - SCAN to DRAIN after the last read is issued.
  - DRAIN to FIN when the FIFO is empty, no read is in flight, and the last pixel has handshaken.
  - FIN to IDLE unconditionally. done=1 in FIN only.
- Scan order is nested counters: outer index o in 0..nrows-1, inner index i in 0..ncols-1.
  - transpose=0: address row=o, col=i.
  - transpose=1: address row=i, col=o.
  - In both cases the inner counter wraps to 0 at ncols-1 and increments the outer counter.
- Read issue rule: issue when (fifo_count + inflight) < FIFO_DEPTH, counting the pop happening in the same cycle. Overflow is therefore impossible.
- Tags: each issued read carries its last_col/last flags through a one-stage pipeline alongside the SRAM data. Data and tags are pushed to the FIFO together.
- Outputs m_data, m_last_col and m_last come from the FIFO head. m_valid equals FIFO not empty.
- start outside IDLE is ignored. Input changes after start have no effect.
- Synchronous rst in any state returns to IDLE and restores reset values. In-flight reads are discarded.

## Timing
- Read latency: sram.dout is valid the cycle after the address and sense_en are presented.
- With m_ready held high:
  - The first m_valid appears 2 cycles after the start cycle: read issued at S+1, data pushed at S+2.
  - Throughput is 1 pixel/cycle.
  - The last pixel handshakes at S+1+nrows*ncols.
  - done is high at S+2+nrows*ncols.
- With m_ready low, at most FIFO_DEPTH pixels are buffered and reads stall. Once m_ready rises, streaming resumes the next cycle with no bubble.
- A push and a pop in the same cycle leave the FIFO count unchanged.
- m_data, m_last_col and m_last are stable while m_valid && !m_ready.
- Index widths:
  - Counters are 8 bits; the inner count reaches at most ncols-1.
  - Terminal compare is o==nrows-1 && i==ncols-1, so 255x255 works without overflow.
  - The image pixel total (up to 65025) is never needed.
- Zero-size image: done pulses at S+1, with no SRAM read and no m_valid.

## Structure
- The shared package conv_pkg holds:
  - pixel_t (logic [7:0]) and idx_t (logic [7:0]).
  - The reader_state_t enum {IDLE, SCAN, DRAIN, FIN}.
  - The tag struct {last_col, last}.
- One sub-module, conv_pix_fifo, parameterised by depth and payload width: synchronous FIFO with push/pop, empty/full and count.

## Test plan
- 3x4 image with distinct values, m_ready=1, transpose=0 → 12 pixels in row-major order at 1/cycle. m_last_col on pixels 4, 8 and 12; m_last on 12; done at S+14.
- Same image with transpose=1 → addresses sweep (0,0),(1,0),(2,0),(3,0),(0,1)…; m_last_col every 4th pixel; 12 pixels total.
- 6x6 image with random m_ready (50%) → exact pixel sequence with no loss or duplication. Reads stall when count+inflight=2. Payload is stable while stalled.
- nrows=0 with ncols=5 → no sense_en, no m_valid, done pulses at S+1. A start during busy is ignored and does not restart the scan.
- rst asserted mid-stream at pixel 7 of 16 → next cycle busy=0, m_valid=0, FIFO empty. A new start rescans from (0,0).
- 255x255 image with m_ready=1 → 65025 pixels; m_last on (254,254); counters do not wrap prematurely.
